// File: rtl/io_timing_harness.sv
// Pin-limited harness around an NCH-channel PE array: serial beats are
// deserialised into load words, store words are folded down to PIN_W bits.
module io_timing_harness #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned PIN_W  = 8,
  parameter int unsigned NCH    = 2
) (
  input  logic                    Clk,
  input  logic                    Resetn,
  input  logic [PIN_W-1:0]        D_in,
  input  logic                    D_in_valid,
  output logic                    D_in_ready,
  input  logic [1:0]              Mode,
  input  logic                    PE_Array_Busy,
  output logic [NCH*DWIDTH-1:0]   Load_Data,
  output logic [NCH-1:0]          Load_Strobe,
  input  logic [NCH*DWIDTH-1:0]   Store_Data,
  output logic [PIN_W-1:0]        D_out,
  output logic                    D_out_valid
);

  localparam int unsigned BEATS = DWIDTH / PIN_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SH_W  = DWIDTH - PIN_W;

  localparam logic [0:0] ST_SHIFT = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SH_W-1:0]   sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [DWIDTH-1:0] hold_q;

  logic [DWIDTH-1:0] word_c;
  logic [DWIDTH-1:0] commit_word_c;
  logic              accept_c;
  logic              last_c;
  logic              commit_c;
  logic              hold_load_c;

  // Only the low DWIDTH-PIN_W bits of the shifter are ever re-read, so only those are stored.
  assign D_in_ready = (state_q == ST_SHIFT);
  assign accept_c   = D_in_valid & D_in_ready;
  assign word_c     = {sh_q, D_in};
  assign last_c     = accept_c & (cnt_q == CNT_W'(BEATS - 1));

  // Next-state and commit decision
  always_comb begin
    state_d       = state_q;
    commit_c      = 1'b0;
    hold_load_c   = 1'b0;
    commit_word_c = word_c;
    case (state_q)
      ST_SHIFT: begin
        if (last_c) begin
          if (PE_Array_Busy) begin
            hold_load_c = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            commit_c = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        commit_word_c = hold_q;
        if (!PE_Array_Busy) begin
          commit_c = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) state_q <= ST_SHIFT;
    else         state_q <= state_d;
  end

  // Deserialiser, hold register and load-port commit
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      sh_q        <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      Load_Data   <= '0;
      Load_Strobe <= '0;
    end else begin
      Load_Strobe <= '0;
      if (accept_c) begin
        sh_q  <= word_c[SH_W-1:0];
        cnt_q <= last_c ? '0 : cnt_q + CNT_W'(1);
      end
      if (hold_load_c) hold_q <= word_c;
      if (commit_c) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          if (Mode[0] || (ptr_q == PTR_W'(c))) begin
            Load_Data[c*DWIDTH +: DWIDTH] <= commit_word_c;
            Load_Strobe[c]                <= 1'b1;
          end
        end
        if (!Mode[0]) ptr_q <= (ptr_q == PTR_W'(NCH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
    end
  end

  logic [NCH-1:0][PIN_W-1:0] fold_c;
  logic [NCH-1:0][PIN_W-1:0] s1_q;
  logic                      op_q;
  logic                      vld1_q;
  logic [PIN_W-1:0]          red_c;

  // Stage 1: fold each channel's BEATS slices
  always_comb begin
    fold_c = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      fold_c[c] = Store_Data[c*DWIDTH +: PIN_W];
      for (int unsigned b = 1; b < BEATS; b++) begin
        fold_c[c] = Mode[1] ? (fold_c[c] ^ Store_Data[c*DWIDTH + b*PIN_W +: PIN_W])
                            : (fold_c[c] & Store_Data[c*DWIDTH + b*PIN_W +: PIN_W]);
      end
    end
  end

  // Stage 2: fold across channels with the op captured alongside stage 1
  always_comb begin
    red_c = s1_q[0];
    for (int unsigned c = 1; c < NCH; c++) begin
      red_c = op_q ? (red_c ^ s1_q[c]) : (red_c & s1_q[c]);
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      s1_q        <= '0;
      op_q        <= 1'b0;
      vld1_q      <= 1'b0;
      D_out       <= '0;
      D_out_valid <= 1'b0;
    end else begin
      s1_q        <= fold_c;
      op_q        <= Mode[1];
      vld1_q      <= ~PE_Array_Busy;
      D_out       <= red_c;
      D_out_valid <= vld1_q;
    end
  end

endmodule

// File: tb/tb_io_timing_harness.sv
// Scoreboard bench for io_timing_harness (DWIDTH=32, PIN_W=8, NCH=2).
module tb_io_timing_harness;

  logic        Clk;
  logic        Resetn;
  logic [7:0]  D_in;
  logic        D_in_valid;
  logic        D_in_ready;
  logic        mode_bcast;
  logic        mode_op;
  logic        busy;
  logic [63:0] Load_Data;
  logic [1:0]  Load_Strobe;
  logic [63:0] Store_Data;
  logic [7:0]  D_out;
  logic        D_out_valid;

  io_timing_harness #(.DWIDTH(32), .PIN_W(8), .NCH(2)) dut (
    .Clk(Clk), .Resetn(Resetn), .D_in(D_in), .D_in_valid(D_in_valid),
    .D_in_ready(D_in_ready), .Mode({mode_op, mode_bcast}), .PE_Array_Busy(busy),
    .Load_Data(Load_Data), .Load_Strobe(Load_Strobe), .Store_Data(Store_Data),
    .D_out(D_out), .D_out_valid(D_out_valid)
  );

  typedef struct { logic [1:0] strobe; logic [63:0] data; int cyc; } load_exp_t;
  typedef struct { logic [7:0] d; logic v; } red_exp_t;

  load_exp_t   lq[$];
  red_exp_t    rq[$];
  logic [31:0] ld_model [2];
  int          m_ptr;
  int          cyc;
  int          checks;
  int          fails;
  logic        dir_en;
  logic [63:0] dir_data;
  logic        dir_op;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Flat reduction over every byte of every channel; AND and XOR are associative.
  function automatic logic [7:0] exp_red(input logic [63:0] sd, input logic op);
    logic [7:0] acc;
    acc = op ? 8'h00 : 8'hFF;
    for (int i = 0; i < 8; i++) acc = op ? (acc ^ sd[8*i +: 8]) : (acc & sd[8*i +: 8]);
    return acc;
  endfunction

  // Store-side driver: random unless a directed value is requested
  initial begin
    Store_Data = '0;
    mode_op    = 1'b0;
    forever begin
      @(negedge Clk);
      if (dir_en) begin
        Store_Data = dir_data;
        mode_op    = dir_op;
      end else begin
        Store_Data = {$urandom, $urandom};
        mode_op    = 1'($urandom_range(0, 1));
      end
    end
  end

  // Reduction reference: sample what the DUT sees at each edge
  always @(posedge Clk) begin
    red_exp_t e;
    if (!Resetn) rq.delete();
    else begin
      e.d = exp_red(Store_Data, mode_op);
      e.v = ~busy;
      rq.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the scoreboards
  always @(negedge Clk) begin
    load_exp_t le;
    red_exp_t  re;
    if (!Resetn) begin
      if (cyc > 0) begin
        checks++;
        if (Load_Data !== '0 || Load_Strobe !== '0 || D_out !== '0 || D_out_valid !== 1'b0) begin
          fails++;
          $display("FAIL reset_outputs got=%h/%b/%h/%b exp=0/0/0/0",
                   Load_Data, Load_Strobe, D_out, D_out_valid);
        end
      end
    end else begin
      if (Load_Strobe != 2'b00) begin
        checks++;
        if (lq.size() == 0) begin
          fails++;
          $display("FAIL load_unexpected got strobe=%b data=%h at cyc %0d exp none", Load_Strobe, Load_Data, cyc);
        end else begin
          le = lq.pop_front();
          if (Load_Strobe !== le.strobe || Load_Data !== le.data || cyc != le.cyc) begin
            fails++;
            $display("FAIL load_commit got strobe=%b data=%h cyc=%0d exp strobe=%b data=%h cyc=%0d",
                     Load_Strobe, Load_Data, cyc, le.strobe, le.data, le.cyc);
          end
        end
      end else if (lq.size() > 0 && cyc > lq[0].cyc) begin
        le = lq.pop_front();
        checks++;
        fails++;
        $display("FAIL load_missing got no strobe by cyc=%0d exp strobe=%b data=%h", cyc, le.strobe, le.data);
      end
      if (rq.size() >= 2) begin
        re = rq.pop_front();
        checks++;
        if (D_out !== re.d || D_out_valid !== re.v) begin
          fails++;
          $display("FAIL reduction got d=%h v=%b exp d=%h v=%b at cyc %0d", D_out, D_out_valid, re.d, re.v, cyc);
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] b, input logic set_busy, output int edge_n);
    int   waited;
    logic acc;
    waited = 0;
    acc    = 1'b0;
    edge_n = 0;
    while (!acc) begin
      @(negedge Clk);
      D_in       = b;
      D_in_valid = 1'b1;
      if (set_busy) busy = 1'b1;
      #1;
      acc    = D_in_ready;
      edge_n = cyc + 1;
      waited++;
      if (!acc && waited > 40) begin
        checks++;
        fails++;
        $display("FAIL beat_accept_timeout got ready=0 exp ready=1");
        acc = 1'b1;
      end
    end
  endtask

  // Send one word MSB-beat first; hold>0 keeps busy high for that many edges from the final beat.
  task automatic send_word(input logic [31:0] w, input int gap, input int hold);
    int        edge_n;
    load_exp_t e;
    for (int i = 0; i < 4; i++) begin
      send_beat(w[31-8*i -: 8], (i == 3) && (hold > 0), edge_n);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge Clk);
          D_in_valid = 1'b0;
        end
      end
    end
    e.strobe = 2'b00;
    if (mode_bcast) begin
      e.strobe    = 2'b11;
      ld_model[0] = w;
      ld_model[1] = w;
    end else begin
      e.strobe[m_ptr] = 1'b1;
      ld_model[m_ptr] = w;
      m_ptr = (m_ptr + 1) % 2;
    end
    e.data = {ld_model[1], ld_model[0]};
    e.cyc  = edge_n + hold;
    lq.push_back(e);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge Clk);
        D_in       = 8'hFF;
        D_in_valid = 1'b1;
        if (k == hold - 1) busy = 1'b0;
        #1;
        checks++;
        if (D_in_ready !== 1'b0) begin
          fails++;
          $display("FAIL hold_ready got=%b exp=0", D_in_ready);
        end
      end
      @(negedge Clk);
      D_in_valid = 1'b0;
      #1;
      checks++;
      if (D_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL release_ready got=%b exp=1", D_in_ready);
      end
    end else begin
      @(negedge Clk);
      D_in_valid = 1'b0;
    end
  endtask

  task automatic check_red(input string name, input logic [63:0] sd, input logic op, input logic [7:0] exp_d);
    @(negedge Clk);
    dir_en   = 1'b1;
    dir_data = sd;
    dir_op   = op;
    repeat (3) @(negedge Clk);
    #1;
    checks++;
    if (D_out !== exp_d || D_out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s got d=%h v=%b exp d=%h v=1", name, D_out, D_out_valid, exp_d);
    end
    dir_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en;
    cyc = 0; checks = 0; fails = 0; m_ptr = 0;
    ld_model[0] = '0; ld_model[1] = '0;
    Resetn = 1'b0; D_in = '0; D_in_valid = 1'b0; busy = 1'b0; mode_bcast = 1'b0;
    dir_en = 1'b0; dir_data = '0; dir_op = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Resetn = 1'b1;

    // Round-robin with pointer wrap
    send_word(32'h11223344, 0, 0);
    send_word(32'hAABBCCDD, 0, 0);
    send_word(32'h01020304, 0, 0);
    // Broadcast leaves the pointer alone
    mode_bcast = 1'b1;
    send_word(32'hA5A55A5A, 0, 0);
    mode_bcast = 1'b0;
    send_word(32'h55667788, 0, 0);
    // Back-pressure for 5 edges, junk offered while not ready
    send_word(32'hCAFEF00D, 0, 5);
    send_word(32'h0BADBEEF, 0, 0);
    // Gapped input
    send_word(32'h13579BDF, 3, 0);

    check_red("red_and", {32'h0F0F0F0F, 32'hFFFFFFFF}, 1'b0, 8'h0F);
    check_red("red_xor", {32'h00000000, 32'h01020304}, 1'b1, 8'h04);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      busy = 1'($urandom_range(0, 1));
    end
    @(negedge Clk);
    busy = 1'b0;

    // Reset in the middle of a word
    send_beat(8'h12, 1'b0, en);
    send_beat(8'h34, 1'b0, en);
    @(negedge Clk);
    D_in_valid = 1'b0;
    #2 Resetn = 1'b0;
    lq.delete();
    m_ptr = 0;
    ld_model[0] = '0; ld_model[1] = '0;
    @(negedge Clk);
    #2 Resetn = 1'b1;
    send_word(32'hDEADBEEF, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      mode_bcast = 1'($urandom_range(0, 1));
      send_word($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
    end

    repeat (6) @(negedge Clk);
    checks++;
    if (lq.size() != 0) begin
      fails++;
      $display("FAIL load_drain got pending=%0d exp 0", lq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/io_timing_harness.md
Name: io_timing_harness

Overview:
- Parametrised pin-limited harness that wraps an NCH-channel PE array for timing closure.
- A narrow serial input port is deserialised into full-width load words and committed to the array's load ports, either round-robin or broadcast.
- The array's store words pass through a 2-stage registered reduction down to a narrow output port.
- Added over the previous generation: valid/ready handshake, busy back-pressure, a selectable reduction operator, and a D_out_valid qualifier.

Parameters:
- DWIDTH, 32: width of each channel's load/store word.
- PIN_W, 8: width of the serial input and reduced output. DWIDTH % PIN_W must be 0.
- NCH, 2: number of load/store channels, NCH >= 1.
- BEATS, DWIDTH/PIN_W: derived, not overridable. Must be >= 2.

Ports:
- Clk  in  1  single clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- D_in  in  PIN_W  serial beat data.
- D_in_valid  in  1  beat present.
- D_in_ready  out  1  harness can accept a beat.
- Mode  in  2  bit0: 1=broadcast, 0=round-robin. bit1: reduction op, 0=AND, 1=XOR.
- PE_Array_Busy  in  1  array busy; blocks load commits.
- Load_Data  out  NCH*DWIDTH  channel c occupies bits [c*DWIDTH +: DWIDTH].
- Load_Strobe  out  NCH  one-cycle pulse per channel written.
- Store_Data  in  NCH*DWIDTH  array store words, same packing as Load_Data.
- D_out  out  PIN_W  reduced store data.
- D_out_valid  out  1  D_out corresponds to a non-busy sample.

Behaviour:
- Reset (async, Resetn=0): Load_Data=0, Load_Strobe=0, D_out=0, D_out_valid=0, shift register=0, beat count=0, ch_ptr=0, state=SHIFT.
  - D_in_ready=1 from the first cycle after reset is released.
  - Reset mid-word discards all partial beats.
- Beat accept: a beat is accepted when D_in_valid && D_in_ready. Gaps in valid are allowed; the beat counter holds across gaps.
- Shift: sh <= {sh[DWIDTH-PIN_W-1:0], D_in}. The first beat received ends up as the MSB byte group.
- Beat counter runs 0..BEATS-1 and wraps to 0 on the final beat.
- State SHIFT, final beat accepted, word W = {sh[DWIDTH-PIN_W-1:0], D_in}:
  - If PE_Array_Busy=0: commit W at this edge. Load_Data and Load_Strobe become visible the next cycle. State stays SHIFT.
  - If PE_Array_Busy=1: latch W into the hold register and go to HOLD.
- State HOLD:
  - D_in_ready=0 (combinational from state).
  - Each cycle with PE_Array_Busy=0: commit the held word and return to SHIFT. D_in_ready is 1 in the following cycle.
- Commit:
  - Mode[0]=0: write channel ch_ptr, assert Load_Strobe[ch_ptr] for exactly 1 cycle, then ch_ptr <= (ch_ptr==NCH-1) ? 0 : ch_ptr+1.
  - Mode[0]=1: write W to all channels, Load_Strobe = all ones for 1 cycle, ch_ptr unchanged.
  - Mode is sampled at the commit edge, not when the word started.
- Load_Data holds its value between commits. Load_Strobe is 0 whenever no commit occurs.
- Reduction pipeline, latency 2 cycles, fully pipelined with a new sample every cycle:
  - Stage 1: per channel, fold DWIDTH down to PIN_W by applying op across its BEATS slices. Register the result.
  - Stage 2: fold the NCH stage-1 results with the same op. Register into D_out.
  - op is Mode[1] sampled at stage 1.
- D_out_valid = ~PE_Array_Busy delayed 2 cycles, aligned with D_out.
- Simultaneous events:
  - Busy rising in the same cycle as the final beat: the busy-at-edge value decides, so the word goes to HOLD.
  - Busy falling: the commit occurs at the first edge where busy is sampled 0.

Test Plan (DWIDTH=32, PIN_W=8, NCH=2):
- Round-robin: contiguous beats 0x11,0x22,0x33,0x44 with Mode=00.
  - Cycle after the 4th beat: ch0 = 0x11223344 and Load_Strobe=01.
  - Next word 0xAABBCCDD: ch1 and strobe=10.
  - Third word 0x01020304: ch0 again (ch_ptr wraps).
- Broadcast: Mode=01, word 0xA5A55A5A -> both channels = 0xA5A55A5A, Load_Strobe=11. The following round-robin word still goes to the unchanged ch_ptr.
- Back-pressure: PE_Array_Busy=1 on the 4th beat and held 5 cycles.
  - D_in_ready=0 and no strobe for those 5 cycles.
  - Strobe is visible the cycle after the first edge with busy=0; D_in_ready=1 the following cycle.
  - Beats offered while ready=0 are not consumed.
- Reduction:
  - Mode[1]=0, ch0=0xFFFFFFFF, ch1=0x0F0F0F0F -> D_out=0x0F after 2 cycles.
  - Mode[1]=1, ch0=0x01020304, ch1=0 -> D_out=0x04.
  - D_out_valid tracks busy with a 2-cycle delay.
- Gapped input: beats with valid de-asserted 3 cycles between each beat -> same word and strobe timing relative to the last beat as contiguous input.
- Reset mid-word: 2 beats, then Resetn low for 1 cycle.
  - All outputs are 0 during reset.
  - The next 4 beats 0xDE,0xAD,0xBE,0xEF commit only 0xDEADBEEF to ch0.
